// File: rtl/rrf_ring.sv
// Multi-port rename register file with circular allocate/commit pointers,
// writeback forwarding, mispredict tail rewind and optional forward-to-read bypass.
module rrf_ring #(
    parameter int RRF_NUM  = 64,
    parameter int DATA_LEN = 32,
    parameter int NUM_RD   = 4,
    parameter int NUM_FWD  = 2,
    parameter int ALLOC_W  = 2,
    parameter int COM_W    = 2,
    parameter int BYPASS   = 1,
    localparam int RRF_SEL = $clog2(RRF_NUM),
    localparam int AW      = $clog2(ALLOC_W + 1),
    localparam int CW      = $clog2(COM_W + 1)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_RD*RRF_SEL-1:0]     rd_tag_i,
    output logic [NUM_RD*DATA_LEN-1:0]    rd_data_o,
    output logic [NUM_RD-1:0]             rd_valid_o,
    input  logic [NUM_FWD-1:0]            fwd_we_i,
    input  logic [NUM_FWD*RRF_SEL-1:0]    fwd_tag_i,
    input  logic [NUM_FWD*DATA_LEN-1:0]   fwd_data_i,
    input  logic [AW-1:0]                 alloc_req_i,
    output logic                          alloc_ok_o,
    output logic [ALLOC_W*RRF_SEL-1:0]    alloc_tag_o,
    input  logic [CW-1:0]                 com_cnt_i,
    output logic [COM_W*RRF_SEL-1:0]      com_tag_o,
    output logic [COM_W*DATA_LEN-1:0]     com_data_o,
    output logic [COM_W-1:0]              com_valid_o,
    input  logic                          flush_i,
    input  logic [RRF_SEL-1:0]            flush_tail_i,
    output logic [RRF_SEL:0]              free_cnt_o
);

    logic [RRF_SEL-1:0]  head_q, tail_q;
    logic [RRF_SEL:0]    occ_q;
    logic [RRF_NUM-1:0]  valid_q;
    logic [DATA_LEN-1:0] data_q [RRF_NUM];

    logic                alloc_go;
    logic [RRF_SEL:0]    alloc_amt, com_amt, flush_occ;

    assign free_cnt_o = (RRF_SEL+1)'(RRF_NUM) - occ_q;
    assign alloc_ok_o = !flush_i && (32'(free_cnt_o) >= 32'(alloc_req_i));
    assign alloc_go   = alloc_ok_o && (alloc_req_i != '0);
    assign alloc_amt  = alloc_go ? (RRF_SEL+1)'(alloc_req_i) : '0;
    assign com_amt    = (RRF_SEL+1)'(com_cnt_i);
    // Ring distance head->flush_tail; equal pointers mean nothing survives.
    assign flush_occ  = {1'b0, flush_tail_i - head_q};

    // Entry lookup with optional same-cycle forward bypass; highest port wins.
    function automatic logic [DATA_LEN:0] lookup(input logic [RRF_SEL-1:0] t);
        logic [DATA_LEN:0] r;
        r = {valid_q[t], data_q[t]};
        if (BYPASS != 0)
            for (int p = 0; p < NUM_FWD; p++)
                if (fwd_we_i[p] && fwd_tag_i[p*RRF_SEL +: RRF_SEL] == t)
                    r = {1'b1, fwd_data_i[p*DATA_LEN +: DATA_LEN]};
        return r;
    endfunction

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        assign {rd_valid_o[k], rd_data_o[k*DATA_LEN +: DATA_LEN]} =
            lookup(rd_tag_i[k*RRF_SEL +: RRF_SEL]);
    end

    for (genvar j = 0; j < ALLOC_W; j++) begin : g_alloc
        assign alloc_tag_o[j*RRF_SEL +: RRF_SEL] = tail_q + RRF_SEL'(j);
    end

    for (genvar j = 0; j < COM_W; j++) begin : g_com
        logic [RRF_SEL-1:0] ctag;
        assign ctag = head_q + RRF_SEL'(j);
        assign com_tag_o[j*RRF_SEL +: RRF_SEL] = ctag;
        assign {com_valid_o[j], com_data_o[j*DATA_LEN +: DATA_LEN]} = lookup(ctag);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            valid_q <= '0;
        end else begin
            head_q <= head_q + RRF_SEL'(com_cnt_i);
            if (flush_i) begin
                tail_q <= flush_tail_i;
                occ_q  <= flush_occ - com_amt;
            end else begin
                tail_q <= tail_q + alloc_amt[RRF_SEL-1:0];
                occ_q  <= occ_q + alloc_amt - com_amt;
            end
            for (int p = 0; p < NUM_FWD; p++)
                if (fwd_we_i[p]) valid_q[fwd_tag_i[p*RRF_SEL +: RRF_SEL]] <= 1'b1;
            // Allocation clears come last so they override a same-cycle forward.
            for (int j = 0; j < ALLOC_W; j++)
                if (alloc_go && j < int'(alloc_req_i))
                    valid_q[tail_q + RRF_SEL'(j)] <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_FWD; p++)
            if (fwd_we_i[p])
                data_q[fwd_tag_i[p*RRF_SEL +: RRF_SEL]] <= fwd_data_i[p*DATA_LEN +: DATA_LEN];
    end

endmodule

// File: tb/tb_rrf_ring.sv
// Directed bench for rrf_ring: a bypassing instance (a) and a non-bypassing one (b)
// share all stimulus, so their pointer state stays identical.
module tb_rrf_ring;
    logic        clk = 1'b0, reset = 1'b1;
    logic [23:0] rd_tag = '0;
    logic [1:0]  fwd_we = '0;
    logic [11:0] fwd_tag = '0;
    logic [63:0] fwd_data = '0;
    logic [1:0]  alloc_req = '0, com_cnt = '0;
    logic        flush = 1'b0;
    logic [5:0]  flush_tail = '0;

    logic [127:0] rd_data_a, rd_data_b;
    logic [3:0]   rd_valid_a, rd_valid_b;
    logic         alloc_ok_a, alloc_ok_b;
    logic [11:0]  alloc_tag_a, alloc_tag_b, com_tag_a, com_tag_b;
    logic [63:0]  com_data_a, com_data_b;
    logic [1:0]   com_valid_a, com_valid_b;
    logic [6:0]   free_a, free_b;

    int checks = 0, failures = 0;

    rrf_ring #(.BYPASS(1)) u_a (
        .clk_i(clk), .reset_i(reset), .rd_tag_i(rd_tag), .rd_data_o(rd_data_a),
        .rd_valid_o(rd_valid_a), .fwd_we_i(fwd_we), .fwd_tag_i(fwd_tag),
        .fwd_data_i(fwd_data), .alloc_req_i(alloc_req), .alloc_ok_o(alloc_ok_a),
        .alloc_tag_o(alloc_tag_a), .com_cnt_i(com_cnt), .com_tag_o(com_tag_a),
        .com_data_o(com_data_a), .com_valid_o(com_valid_a), .flush_i(flush),
        .flush_tail_i(flush_tail), .free_cnt_o(free_a));

    rrf_ring #(.BYPASS(0)) u_b (
        .clk_i(clk), .reset_i(reset), .rd_tag_i(rd_tag), .rd_data_o(rd_data_b),
        .rd_valid_o(rd_valid_b), .fwd_we_i(fwd_we), .fwd_tag_i(fwd_tag),
        .fwd_data_i(fwd_data), .alloc_req_i(alloc_req), .alloc_ok_o(alloc_ok_b),
        .alloc_tag_o(alloc_tag_b), .com_cnt_i(com_cnt), .com_tag_o(com_tag_b),
        .com_data_o(com_data_b), .com_valid_o(com_valid_b), .flush_i(flush),
        .flush_tail_i(flush_tail), .free_cnt_o(free_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Commit count must never exceed occupancy; then advance one clock.
    task automatic tick();
        chk("com_le_occ", 64'(int'(com_cnt) <= 64 - int'(free_a)), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_fwd(input int p, input logic [5:0] t, input logic [31:0] d);
        fwd_we[p] = 1'b1;
        fwd_tag[p*6 +: 6] = t;
        fwd_data[p*32 +: 32] = d;
    endtask

    initial begin
        #3 reset = 1'b0;
        alloc_req = 2'd2;
        settle();
        chk("rst_free", 64'(free_a), 64'd64);
        chk("rst_ok", 64'(alloc_ok_a), 64'd1);
        chk("rst_alloc_tag", 64'(alloc_tag_a), 64'({6'd1, 6'd0}));
        chk("rst_com_tag", 64'(com_tag_a), 64'({6'd1, 6'd0}));
        chk("rst_rd_valid", 64'(rd_valid_a), 64'd0);
        chk("rst_com_valid", 64'(com_valid_a), 64'd0);

        // Fill the ring two entries per cycle.
        for (int i = 0; i < 32; i++) begin
            chk("fill_tags", 64'(alloc_tag_a), 64'({6'(2*i+1), 6'(2*i)}));
            chk("fill_free", 64'(free_a), 64'(64 - 2*i));
            tick();
        end
        alloc_req = 2'd1;
        settle();
        chk("full_free", 64'(free_a), 64'd0);
        chk("full_ok_req1", 64'(alloc_ok_a), 64'd0);
        chk("full_tail_wrap", 64'(alloc_tag_a), 64'({6'd1, 6'd0}));
        alloc_req = 2'd0;
        settle();
        chk("full_ok_req0", 64'(alloc_ok_a), 64'd1);

        // Bypass: tag 5 via port 0 on a read port, tag 0 via port 1 on commit port.
        set_fwd(0, 6'd5, 32'hDEAD);
        set_fwd(1, 6'd0, 32'h77);
        rd_tag[0 +: 6] = 6'd5;
        rd_tag[6 +: 6] = 6'd0;
        settle();
        chk("byp_rd_data", 64'(rd_data_a[31:0]), 64'hDEAD);
        chk("byp_rd_valid", 64'(rd_valid_a[0]), 64'd1);
        chk("nobyp_rd_valid", 64'(rd_valid_b[0]), 64'd0);
        chk("byp_com_data", 64'(com_data_a[31:0]), 64'h77);
        chk("byp_com_valid", 64'(com_valid_a[0]), 64'd1);
        chk("nobyp_com_valid", 64'(com_valid_b[0]), 64'd0);
        tick();
        fwd_we = '0;
        settle();
        chk("late_rd_data", 64'(rd_data_b[31:0]), 64'hDEAD);
        chk("late_rd_valid", 64'(rd_valid_b[1:0]), 64'd3);
        chk("late_com_data", 64'(com_data_b[31:0]), 64'h77);

        // Two ports on tag 9: port 1 must win.
        set_fwd(0, 6'd9, 32'h1);
        set_fwd(1, 6'd9, 32'h2);
        rd_tag[12 +: 6] = 6'd9;
        settle();
        chk("dup_byp", 64'(rd_data_a[95:64]), 64'h2);
        tick();
        fwd_we = '0;
        settle();
        chk("dup_stored", 64'(rd_data_b[95:64]), 64'h2);
        chk("dup_valid", 64'(rd_valid_b[2]), 64'd1);

        // Rewind the full ring to tail=9 (head=0 -> occ=9).
        flush = 1'b1;
        flush_tail = 6'd9;
        settle();
        chk("flush_ok", 64'(alloc_ok_a), 64'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("rew_tail", 64'(alloc_tag_a[5:0]), 64'd9);
        chk("rew_free", 64'(free_a), 64'd55);

        // Allocate tag 9 while forwarding to it: allocation clear wins.
        alloc_req = 2'd1;
        set_fwd(0, 6'd9, 32'h55);
        settle();
        chk("allocfwd_byp", 64'(rd_valid_a[2]), 64'd1);
        tick();
        fwd_we = '0;
        alloc_req = 2'd0;
        settle();
        chk("allocfwd_valid_a", 64'(rd_valid_a[2]), 64'd0);
        chk("allocfwd_valid_b", 64'(rd_valid_b[2]), 64'd0);
        chk("allocfwd_free", 64'(free_a), 64'd54);
        chk("allocfwd_tail", 64'(alloc_tag_a[5:0]), 64'd10);

        // Move to head=10, tail=20, then flush to 14 with one commit.
        alloc_req = 2'd2;
        com_cnt = 2'd2;
        for (int i = 0; i < 5; i++) tick();
        com_cnt = 2'd1;
        flush = 1'b1;
        flush_tail = 6'd14;
        settle();
        chk("pre_com_tag", 64'(com_tag_a), 64'({6'd11, 6'd10}));
        chk("pre_alloc_tag", 64'(alloc_tag_a), 64'({6'd21, 6'd20}));
        chk("pre_free", 64'(free_a), 64'd54);
        chk("flush_blocks_alloc", 64'(alloc_ok_a), 64'd0);
        tick();
        flush = 1'b0;
        com_cnt = 2'd0;
        alloc_req = 2'd0;
        settle();
        chk("flush_head", 64'(com_tag_a[5:0]), 64'd11);
        chk("flush_tail", 64'(alloc_tag_a[5:0]), 64'd14);
        chk("flush_free", 64'(free_a), 64'd61);

        // Walk to head=62, tail=2 across the wrap.
        for (int i = 0; i < 26; i++) begin
            alloc_req = 2'd2;
            com_cnt = (i < 25) ? 2'd2 : 2'd1;
            tick();
        end
        alloc_req = 2'd0;
        com_cnt = 2'd0;
        set_fwd(0, 6'd62, 32'hA62);
        set_fwd(1, 6'd63, 32'hA63);
        tick();
        fwd_we = '0;
        com_cnt = 2'd2;
        settle();
        chk("wrap_alloc_tag", 64'(alloc_tag_a), 64'({6'd3, 6'd2}));
        chk("wrap_com_tag", 64'(com_tag_a), 64'({6'd63, 6'd62}));
        chk("wrap_com_valid", 64'(com_valid_b), 64'd3);
        chk("wrap_com_data", com_data_b, {32'hA63, 32'hA62});
        chk("wrap_free_pre", 64'(free_a), 64'd60);
        tick();
        com_cnt = 2'd0;
        settle();
        chk("wrap_head", 64'(com_tag_a), 64'({6'd1, 6'd0}));
        chk("wrap_free_post", 64'(free_a), 64'd62);

        // Build occ=30, then reset between edges.
        alloc_req = 2'd2;
        for (int i = 0; i < 14; i++) tick();
        alloc_req = 2'd0;
        rd_tag = {6'd63, 6'd62, 6'd63, 6'd62};
        settle();
        chk("occ30_free", 64'(free_a), 64'd34);
        chk("occ30_rd_valid", 64'(rd_valid_a), 64'hF);
        #3 reset = 1'b1;
        #1;
        chk("async_free", 64'(free_a), 64'd64);
        chk("async_head", 64'(com_tag_a), 64'({6'd1, 6'd0}));
        chk("async_tail", 64'(alloc_tag_a), 64'({6'd1, 6'd0}));
        chk("async_rd_valid_a", 64'(rd_valid_a), 64'd0);
        chk("async_rd_valid_b", 64'(rd_valid_b), 64'd0);
        #1 reset = 1'b0;
        settle();
        chk("post_rst_free", 64'(free_b), 64'd64);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
